// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver. The asynchronous rx_i line passes through a two-flop
// synchroniser. The synchronised value is sampled in the middle of each bit,
// and each completed byte goes into a single holding register that the
// consumer reads through a valid/ready handshake. Framing errors and overruns
// are reported as sticky flags, and clear_err_i clears both.
//
// Ports
//   clock_i      in   1  system clock, rising edge
//   resetb_i     in   1  asynchronous active-low reset
//   rx_i         in   1  serial input, idle high, asynchronous
//   rx_data_o    out  8  received byte, valid while rx_valid_o=1
//   rx_valid_o   out  1  holding register full
//   rx_ready_i   in   1  consumer accepts byte when rx_valid_o & rx_ready_i
//   rx_busy_o    out  1  frame in progress (state != IDLE)
//   frame_err_o  out  1  sticky: stop bit sampled low
//   overrun_o    out  1  sticky: byte completed while holding register full
//   clear_err_i  in   1  synchronous clear of frame_err_o and overrun_o
//
// State      | Meaning
// -----------+---------------------------------------------------------------
// IDLE       | line idle, waiting for a low level on the synced line
// START      | confirming the start bit at half a bit time
// DATA       | sampling 8 data bits at mid-bit, LSB first
// STOP       | sampling the stop bit
// WAIT_HIGH  | stop bit was low; wait for the line to go high before re-arming
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_busy_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clear_err_i
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             deliver_q, deliver_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sync1_q, sync2_q;
  logic             rs;
  logic             ferr_set;
  logic             accept;

  // The synchroniser resets high so that leaving reset does not look like a
  // start bit.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rs = sync2_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    deliver_d = 1'b0;
    ferr_set  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again by mid-start was only a glitch.
          state_d   = rs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rs, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rs) begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register and sticky flags. A delivery loads the new byte when the
  // register is empty, or when its current byte is being taken in the same
  // cycle. Otherwise the new byte is dropped and overrun is set.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    accept      = rx_valid_q & rx_ready_i;

    if (deliver_q) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (clear_err_i) begin
      frame_err_d = 1'b0;
      if (!(deliver_q && rx_valid_q && !accept)) overrun_d = 1'b0;
    end
    if (ferr_set) frame_err_d = 1'b1;
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_busy_o   = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core with CLKS_PER_BIT=16. A serial driver builds 8N1
// frames. A negedge monitor records every byte the consumer takes, and each
// scenario task compares that record with the bytes it expects.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clock;
  logic       resetb;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       clear_err;

  int         n_checks;
  int         n_fail;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clock_i    (clock),
    .resetb_i   (resetb),
    .rx_i       (rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .rx_busy_o  (rx_busy),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .clear_err_i(clear_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetb && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends one 8N1 frame starting just after a rising edge. If stop is 0, the
  // line is held low for extra_low more cycles after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clock);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clock);
    if (extra_low > 0) repeat (extra_low) @(posedge clock);
    #1 rx = 1'b1;
  endtask

  task automatic check_queue(input string name);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: received %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %h, expected %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    resetb = 1'b0; rx = 1'b1; rx_ready = 1'b1; clear_err = 1'b0;
    idle(5);
    n_checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b ferr=%b ovr=%b, expected all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
    resetb = 1'b1;
    idle(5);
    n_checks++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", rx_busy, rx_valid);
    end
  endtask

  task automatic test_basic;
    got_q.delete(); exp_q.delete();
    fork
      send_frame(8'h0F, 1'b1, 0);
      begin
        idle(80);
        n_checks++;
        if (rx_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_busy_mid: busy=%b, expected 1", rx_busy);
        end
      end
    join
    exp_q.push_back(8'h0F);
    idle(4);
    send_frame(8'h3D, 1'b1, 0);
    exp_q.push_back(8'h3D);
    idle(4);
    check_queue("basic");
    n_checks++;
    if (rx_data !== 8'h3D || rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_final: data=%h busy=%b ferr=%b ovr=%b, expected 3d 0 0 0",
               rx_data, rx_busy, frame_err, overrun);
    end
  endtask

  task automatic test_glitch;
    got_q.delete(); exp_q.delete();
    @(posedge clock);
    #1 rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check_queue("glitch");
    n_checks++;
    if (rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_flags: busy=%b ferr=%b ovr=%b valid=%b, expected 0 0 0 0",
               rx_busy, frame_err, overrun, rx_valid);
    end
  endtask

  task automatic test_frame_err;
    got_q.delete(); exp_q.delete();
    send_frame(8'hA5, 1'b0, 100);
    idle(8);
    check_queue("ferr_drop");
    n_checks++;
    if (frame_err !== 1'b1 || rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_set: ferr=%b busy=%b valid=%b, expected 1 0 0", frame_err, rx_busy, rx_valid);
    end
    send_frame(8'h5A, 1'b1, 0);
    exp_q.push_back(8'h5A);
    idle(4);
    check_queue("ferr_next");
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_sticky: ferr=%b, expected 1", frame_err);
    end
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    idle(1);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_clear: ferr=%b, expected 0", frame_err);
    end
  endtask

  task automatic test_overrun;
    got_q.delete(); exp_q.delete();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    idle(4);
    send_frame(8'h22, 1'b1, 0);
    idle(4);
    check_queue("ovr_held");
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_state: valid=%b data=%h ovr=%b ferr=%b, expected 1 11 1 0",
               rx_valid, rx_data, overrun, frame_err);
    end
    rx_ready = 1'b1;
    idle(2);
    exp_q.push_back(8'h11);
    check_queue("ovr_drain");
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_valid_clear: valid=%b, expected 0", rx_valid);
    end
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: ovr=%b, expected 0", overrun);
    end
  endtask

  // The byte is delivered in the cycle after the stop-bit sample. That cycle
  // ends at edge 3 + CPB/2 + 9*CPB + 1 after the edge where the start bit
  // begins, so rx_ready is raised for exactly that one edge.
  task automatic test_back_to_back;
    logic [7:0] x;
    logic [7:0] y;
    x = 8'($urandom_range(0, 255));
    y = 8'h96;
    got_q.delete(); exp_q.delete();
    rx_ready = 1'b0;
    send_frame(x, 1'b1, 0);
    idle(4);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== x) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b data=%h, expected 1 %h", rx_valid, rx_data, x);
    end
    fork
      send_frame(y, 1'b1, 0);
      begin
        @(posedge clock);
        repeat (3 + CPB / 2 + 9 * CPB) @(posedge clock);
        #1 rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
      end
    join
    idle(4);
    exp_q.push_back(x);
    check_queue("b2b_taken");
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== y || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reload: valid=%b data=%h ovr=%b, expected 1 %h 0", rx_valid, rx_data, overrun, y);
    end
    rx_ready = 1'b1;
    idle(2);
    exp_q.push_back(y);
    check_queue("b2b_drain");
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'hC3;
    got_q.delete(); exp_q.delete();
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clock);
    end
    #1;
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_busy: busy=%b, expected 1", rx_busy);
    end
    resetb = 1'b0;
    #2;
    n_checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: data=%h valid=%b busy=%b ferr=%b ovr=%b, expected all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
    rx = 1'b1;
    idle(3);
    resetb = 1'b1;
    idle(4);
    send_frame(8'h3C, 1'b1, 0);
    exp_q.push_back(8'h3C);
    idle(4);
    check_queue("rstmid_next");
    n_checks++;
    if (rx_data !== 8'h3C || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_final: data=%h ferr=%b ovr=%b, expected 3c 0 0", rx_data, frame_err, overrun);
    end
  endtask

  // Random bytes, some sent with a bad stop bit. Under the receiver's rules,
  // a good frame is delivered unchanged and a bad frame is dropped and sets
  // frame_err.
  task automatic test_random;
    logic [7:0] b;
    logic       good;
    logic       exp_ferr;
    got_q.delete(); exp_q.delete();
    exp_ferr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, good ? 0 : int'($urandom_range(0, 20)));
      if (good) exp_q.push_back(b);
      else exp_ferr = 1'b1;
      idle(2 + int'($urandom_range(0, 20)));
    end
    idle(4);
    check_queue("random");
    n_checks++;
    if (frame_err !== exp_ferr || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL random_flags: ferr=%b ovr=%b, expected %b 0", frame_err, overrun, exp_ferr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
